udp_receiver: RTL and testbench
===============================

Name: udp_receiver

Overview:
- Receive-side counterpart to the UDP byte-stream transmitter.
- Consumes a byte stream framed by a contiguous run of in_valid high, parses the 8-byte UDP header (src port, dst port, length, checksum) and filters on destination port.
- Forwards payload bytes with valid/last markers and reports per-frame completion or error.
- Sits between the IP-layer deframer and application consumers.

Parameters:
- LOCAL_PORT, 16'd5001, destination port accepted when CHECK_PORT=1.
- CHECK_PORT, 1, 1 = drop frames whose dst port != LOCAL_PORT; 0 = accept any port.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_data  in  8  received byte, sampled when in_valid=1.
- in_valid  in  1  high for every byte of one frame. Frames are separated by at least one low cycle.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid this cycle.
- out_last  out  1  with out_valid, marks final payload byte.
- src_port  out  16  captured source port, stable from hdr_valid until next frame's header.
- dst_port  out  16  captured destination port.
- udp_len  out  16  captured length field (header + payload).
- hdr_valid  out  1  one-cycle pulse: header parsed and accepted.
- frame_done  out  1  one-cycle pulse: frame ended cleanly.
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  valid with frame_err: 1 BADLEN (udp_len<8), 2 PORT, 3 TRUNC; holds last value otherwise.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - All outputs go to 0; state goes to SYNC; byte counter goes to 0.
  - SYNC waits for a cycle with in_valid=0 before moving to IDLE, so a frame in progress at reset release is never parsed misaligned.
- States:
  - SYNC: to IDLE when in_valid=0.
  - IDLE: first byte with in_valid=1 is header byte 0 (dst... src_port[15:8]); go to HDR with count=1.
  - HDR: bytes 1..7 are stored big-endian; the checksum (bytes 6-7) is ignored. On accepting byte 7:
    - udp_len<8: go to DROP, err BADLEN.
    - CHECK_PORT=1 and dst_port!=LOCAL_PORT: go to DROP, err PORT.
    - Otherwise: hdr_valid pulses the next cycle. Go to PAYLOAD if udp_len>8, or to PAD if udp_len==8.
  - PAYLOAD: each accepted byte appears on out_data/out_valid 1 cycle later (registered, latency 1). out_last is set on the byte with index udp_len-1. After that byte, go to PAD.
  - PAD: bytes beyond udp_len (link padding) are swallowed with no output.
  - DROP: swallow all bytes until in_valid=0.
- Frame end (first cycle with in_valid=0 while in HDR/PAYLOAD/PAD/DROP): on the next cycle exactly one of the following pulses, then the state returns to IDLE.
  - PAD: frame_done.
  - DROP: frame_err with the recorded code.
  - HDR or PAYLOAD (ended early): frame_err, err_code=TRUNC. out_last is never asserted for a truncated frame.
- Byte counter: 16-bit, saturates at 16'hFFFF and does not wrap. Frames longer than 65535 bytes stay in PAD.
- Simultaneous events:
  - frame_done/frame_err and hdr_valid never pulse in the same cycle.
  - rst_n=0 overrides everything, including a pending end-of-frame pulse.
- Registers src_port/dst_port/udp_len update only from captured header bytes and are not cleared between frames.

Decomposition:
- Shared package udp_pkg:
  - state enum (SYNC, IDLE, HDR, PAYLOAD, PAD, DROP)
  - err_code constants (ERR_NONE=0, ERR_BADLEN=1, ERR_PORT=2, ERR_TRUNC=3)
  - UDP_HDR_LEN=8
- Single module; no sub-module warranted.

Test Plan:
- Header 13 88 13 89 00 13 00 00 + "Hello World" (11 bytes), then in_valid low:
  - hdr_valid pulse with src_port=5000, dst_port=5001, udp_len=19.
  - 11 out_valid bytes 48..64; out_last on 64.
  - frame_done 1 cycle after in_valid falls.
- Same frame with dst 0x1390 (5008), CHECK_PORT=1 -> no hdr_valid, no out_valid; frame_err with err_code=2.
- udp_len=0x0014 (20) but only 11 payload bytes sent -> 11 out_valid with no out_last; frame_err with err_code=3.
- udp_len=0x0008, then 4 padding bytes -> hdr_valid, zero out_valid, frame_done. Also udp_len=0x0005 -> frame_err with err_code=1.
- rst_n low for 2 cycles mid-payload, released with in_valid still high -> no output until in_valid drops. The next well-formed frame is parsed correctly.
- Back-to-back frames separated by one idle cycle -> two independent hdr_valid/frame_done sequences; header fields update to the second frame's values.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path: parser states, error codes
// and the fixed header length.
package udp_pkg;

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        HDR,
        PAYLOAD,
        PAD,
        DROP
    } state_t;

    localparam logic [1:0]  ERR_NONE    = 2'd0;
    localparam logic [1:0]  ERR_BADLEN  = 2'd1;
    localparam logic [1:0]  ERR_PORT    = 2'd2;
    localparam logic [1:0]  ERR_TRUNC   = 2'd3;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/udp_receiver.sv
// UDP receive parser: strips the 8-byte header, filters on destination port,
// forwards payload with a one-cycle registered latency and flags frame outcome.
module udp_receiver
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT = 16'd5001,
    parameter bit          CHECK_PORT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic        hdr_valid,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    state_t      state, state_p0;
    logic [15:0] cnt, cnt_p0;
    logic [1:0]  err_rec, err_rec_p0;

    logic        vld_p0;
    logic        last_p0;
    logic        hdr_valid_p0;
    logic        frame_done_p0;
    logic        frame_err_p0;
    logic [1:0]  err_code_p0;
    logic [15:0] src_p0, dst_p0, len_p0;

    always_comb begin
        state_p0      = state;
        cnt_p0        = cnt;
        err_rec_p0    = err_rec;
        vld_p0        = 1'b0;
        last_p0       = 1'b0;
        hdr_valid_p0  = 1'b0;
        frame_done_p0 = 1'b0;
        frame_err_p0  = 1'b0;
        err_code_p0   = err_code;
        src_p0        = src_port;
        dst_p0        = dst_port;
        len_p0        = udp_len;

        case (state)
            SYNC: begin
                cnt_p0 = 16'd0;
                if (!in_valid) state_p0 = IDLE;
            end

            IDLE: begin
                if (in_valid) begin
                    src_p0[15:8] = in_data;
                    cnt_p0       = 16'd1;
                    state_p0     = HDR;
                end
            end

            HDR: begin
                if (!in_valid) begin
                    frame_err_p0 = 1'b1;
                    err_code_p0  = ERR_TRUNC;
                    cnt_p0       = 16'd0;
                    state_p0     = IDLE;
                end else begin
                    cnt_p0 = sat_inc16(cnt);
                    case (cnt[2:0])
                        3'd1: src_p0[7:0]  = in_data;
                        3'd2: dst_p0[15:8] = in_data;
                        3'd3: dst_p0[7:0]  = in_data;
                        3'd4: len_p0[15:8] = in_data;
                        3'd5: len_p0[7:0]  = in_data;
                        // Checksum bytes 6 and 7 are not verified; byte 7 closes the header.
                        3'd7: begin
                            if (udp_len < UDP_HDR_LEN) begin
                                err_rec_p0 = ERR_BADLEN;
                                state_p0   = DROP;
                            end else if (CHECK_PORT && (dst_port != LOCAL_PORT)) begin
                                err_rec_p0 = ERR_PORT;
                                state_p0   = DROP;
                            end else begin
                                hdr_valid_p0 = 1'b1;
                                state_p0     = (udp_len == UDP_HDR_LEN) ? PAD : PAYLOAD;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            PAYLOAD: begin
                if (!in_valid) begin
                    frame_err_p0 = 1'b1;
                    err_code_p0  = ERR_TRUNC;
                    cnt_p0       = 16'd0;
                    state_p0     = IDLE;
                end else begin
                    vld_p0 = 1'b1;
                    cnt_p0 = sat_inc16(cnt);
                    if (cnt == udp_len - 16'd1) begin
                        last_p0  = 1'b1;
                        state_p0 = PAD;
                    end
                end
            end

            PAD: begin
                if (!in_valid) begin
                    frame_done_p0 = 1'b1;
                    cnt_p0        = 16'd0;
                    state_p0      = IDLE;
                end else begin
                    cnt_p0 = sat_inc16(cnt);
                end
            end

            DROP: begin
                if (!in_valid) begin
                    frame_err_p0 = 1'b1;
                    err_code_p0  = err_rec;
                    cnt_p0       = 16'd0;
                    state_p0     = IDLE;
                end else begin
                    cnt_p0 = sat_inc16(cnt);
                end
            end

            default: state_p0 = SYNC;
        endcase
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SYNC;
            cnt        <= 16'd0;
            err_rec    <= ERR_NONE;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            src_port   <= 16'd0;
            dst_port   <= 16'd0;
            udp_len    <= 16'd0;
            hdr_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            state      <= state_p0;
            cnt        <= cnt_p0;
            err_rec    <= err_rec_p0;
            out_valid  <= vld_p0;
            out_last   <= last_p0;
            src_port   <= src_p0;
            dst_port   <= dst_p0;
            udp_len    <= len_p0;
            hdr_valid  <= hdr_valid_p0;
            frame_done <= frame_done_p0;
            frame_err  <= frame_err_p0;
            err_code   <= err_code_p0;
            if (vld_p0) out_data <= in_data;
        end
    end

endmodule

// File: tb/tb_udp_receiver.sv
// Bench for udp_receiver: directed frames, a frame-level expectation model and
// a per-cycle comparison of every output.
module tb_udp_receiver;
    localparam logic [15:0] LOCAL_PORT = 16'd5001;
    localparam int          NEXP       = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid, out_last;
    logic [15:0] src_port, dst_port, udp_len;
    logic        hdr_valid, frame_done, frame_err;
    logic [1:0]  err_code;

    udp_receiver #(.LOCAL_PORT(LOCAL_PORT), .CHECK_PORT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .src_port(src_port), .dst_port(dst_port), .udp_len(udp_len),
        .hdr_valid(hdr_valid), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        last;
        logic        hv;
        logic        fd;
        logic        fe;
        logic [1:0]  ec;
        logic [15:0] sp;
        logic [15:0] dp;
        logic [15:0] ln;
    } exp_t;

    exp_t expv [0:NEXP-1];

    int errors = 0;
    int checks = 0;
    int nvalid = 0, nlast = 0, nfd = 0;
    logic [7:0] last_byte = 8'd0;

    logic [7:0] hello [0:10] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64};
    logic [7:0] fq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] ln,
                         input int npay, input int npad);
        fq.delete();
        fq.push_back(sp[15:8]); fq.push_back(sp[7:0]);
        fq.push_back(dp[15:8]); fq.push_back(dp[7:0]);
        fq.push_back(ln[15:8]); fq.push_back(ln[7:0]);
        fq.push_back(8'h00);    fq.push_back(8'h00);
        for (int k = 0; k < npay; k++) fq.push_back(hello[k % 11]);
        for (int k = 0; k < npad; k++) fq.push_back(8'hEE);
    endtask

    // Frame outcome from the header fields; byte i is sampled at edge c+1+i.
    task automatic model_frame(input int c, input int rst_at);
        int n;
        int npay;
        int endi;
        logic [15:0] sp, dp, ln;
        n    = fq.size();
        endi = c + 1 + n;
        if (n < 8) begin
            expv[endi].fe = 1'b1;
            expv[endi].ec = 2'd3;
        end else begin
            sp = {fq[0], fq[1]};
            dp = {fq[2], fq[3]};
            ln = {fq[4], fq[5]};
            if (ln < 16'd8) begin
                expv[endi].fe = 1'b1;
                expv[endi].ec = 2'd1;
            end else if (dp != LOCAL_PORT) begin
                expv[endi].fe = 1'b1;
                expv[endi].ec = 2'd2;
            end else begin
                expv[c+8].hv = 1'b1;
                expv[c+8].sp = sp;
                expv[c+8].dp = dp;
                expv[c+8].ln = ln;
                npay = (int'(ln) - 8 < n - 8) ? int'(ln) - 8 : n - 8;
                for (int k = 0; k < npay; k++) begin
                    expv[c+9+k].v    = 1'b1;
                    expv[c+9+k].d    = fq[8+k];
                    expv[c+9+k].last = (8 + k == int'(ln) - 1);
                end
                if (int'(ln) <= n) expv[endi].fd = 1'b1;
                else begin
                    expv[endi].fe = 1'b1;
                    expv[endi].ec = 2'd3;
                end
            end
        end
        if (rst_at >= 0)
            for (int i = c + 1 + rst_at; i <= endi; i++) expv[i] = '0;
    endtask

    task automatic send(input int gap, input int rst_at);
        int c;
        c = cyc;
        model_frame(c, rst_at);
        for (int i = 0; i < fq.size(); i++) begin
            in_data  = fq[i];
            in_valid = 1'b1;
            rst_n    = !(rst_at >= 0 && (i == rst_at || i == rst_at + 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    initial begin
        for (int i = 0; i < NEXP; i++) expv[i] = '0;
        fork
            forever begin
                @(negedge clk);
                if (cyc >= 1 && cyc < NEXP) begin
                    exp_t e;
                    e = expv[cyc];
                    chk("out_valid", {31'd0, out_valid}, {31'd0, e.v});
                    if (e.v) chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                    chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                    chk("hdr_valid", {31'd0, hdr_valid}, {31'd0, e.hv});
                    chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
                    if (e.fe) chk("err_code", {30'd0, err_code}, {30'd0, e.ec});
                    if (e.hv) begin
                        chk("src_port", {16'd0, src_port}, {16'd0, e.sp});
                        chk("dst_port", {16'd0, dst_port}, {16'd0, e.dp});
                        chk("udp_len",  {16'd0, udp_len},  {16'd0, e.ln});
                    end
                    if (out_valid) begin
                        nvalid++;
                        if (out_last) begin nlast++; last_byte = out_data; end
                    end
                    if (frame_done) nfd++;
                end
            end
            begin
                int v0, l0, f0;
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("rst_src_port", {16'd0, src_port}, 32'd0);
                chk("rst_udp_len", {16'd0, udp_len}, 32'd0);
                chk("rst_err_code", {30'd0, err_code}, 32'd0);
                rst_n = 1'b1;
                @(posedge clk); #1;

                // Hello World frame
                v0 = nvalid; l0 = nlast; f0 = nfd;
                build(16'd5000, 16'd5001, 16'd19, 11, 0);
                send(3, -1);
                chk("hello_count", nvalid - v0, 32'd11);
                chk("hello_last_count", nlast - l0, 32'd1);
                chk("hello_last_byte", {24'd0, last_byte}, 32'h64);
                chk("hello_done_count", nfd - f0, 32'd1);
                chk("hello_src", {16'd0, src_port}, 32'd5000);
                chk("hello_dst", {16'd0, dst_port}, 32'd5001);
                chk("hello_len", {16'd0, udp_len}, 32'd19);

                // Wrong destination port
                v0 = nvalid;
                build(16'd5000, 16'd5008, 16'd19, 11, 0);
                send(3, -1);
                chk("port_count", nvalid - v0, 32'd0);
                chk("port_code", {30'd0, err_code}, 32'd2);

                // Truncated payload
                v0 = nvalid; l0 = nlast;
                build(16'd5000, 16'd5001, 16'd20, 11, 0);
                send(3, -1);
                chk("trunc_count", nvalid - v0, 32'd11);
                chk("trunc_last_count", nlast - l0, 32'd0);
                chk("trunc_code", {30'd0, err_code}, 32'd3);

                // Header-only frame with padding
                v0 = nvalid; f0 = nfd;
                build(16'd5000, 16'd5001, 16'd8, 0, 4);
                send(3, -1);
                chk("hdronly_count", nvalid - v0, 32'd0);
                chk("hdronly_done", nfd - f0, 32'd1);

                // Length below header size
                build(16'd5000, 16'd5001, 16'd5, 0, 2);
                send(3, -1);
                chk("badlen_code", {30'd0, err_code}, 32'd1);

                // Reset mid-payload, released while the frame still runs
                v0 = nvalid; f0 = nfd;
                build(16'd5000, 16'd5001, 16'd19, 11, 0);
                send(3, 12);
                chk("rst_frame_count", nvalid - v0, 32'd4);
                chk("rst_frame_done", nfd - f0, 32'd0);
                build(16'd4000, 16'd5001, 16'd19, 11, 2);
                send(3, -1);
                chk("after_rst_src", {16'd0, src_port}, 32'd4000);

                // Back-to-back frames, one idle cycle apart
                f0 = nfd;
                build(16'd1234, 16'd5001, 16'd12, 4, 0);
                send(1, -1);
                build(16'd4321, 16'd5001, 16'd10, 2, 1);
                send(3, -1);
                chk("b2b_done", nfd - f0, 32'd2);
                chk("b2b_src", {16'd0, src_port}, 32'd4321);
                chk("b2b_len", {16'd0, udp_len}, 32'd10);

                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join
    end

endmodule
